// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU main controller: states, opcodes,
// ALU operation classes and datapath mux selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic uses_reg_b(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode to ALU operation class map, with a flag marking
// opcodes the controller knows how to execute.
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: alu_op = ALU_RTYPE;
            OP_BEQ:   alu_op = ALU_SUB;
            OP_BNE:   alu_op = ALU_BNE;
            OP_LW,
            OP_SW,
            OP_ADDI,
            OP_J:     alu_op = ALU_ADD;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_SLTI:  alu_op = ALU_SLT;
            default:  legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle CPU main controller (fetch/decode/exec/mem/writeback).
// Define MEM_WAIT_EN to make FETCH and MEM stall until mem_ready.
//
// state  | meaning
// FETCH  | read instruction, PC+4 (pc_write on exit)
// DECODE | compute branch target; j completes, undefined opcodes trap
// EXEC   | ALU operation; branches resolve here
// MEM    | data memory access for lw/sw
// WB     | register file write
module main_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [2:0]  ALUOp,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        illegal_op,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    state_t      state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] count_q;
    logic        run_q;
    logic        retire;
    logic        mem_go;
    logic [2:0]  dec_alu_op;
    logic        dec_legal;

    logic [2:0]  alu_op_d;
    logic        pc_write_d, ir_write_d, mem_read_d, mem_write_d;
    logic        reg_write_d, reg_dst_d, mem_to_reg_d, alu_src_a_d;
    logic        branch_eq_d, branch_ne_d, illegal_d;
    logic [1:0]  alu_src_b_d, pc_src_d;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_go = 1'b1;
`endif

    alu_op_decode u_alu_op_decode (
        .opcode (op_q),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // run_q holds everything quiet for the first cycle after reset release,
    // so FETCH is first visible one cycle after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else if (run_q) begin
            state_q <= state_d;
            if (state_q == ST_FETCH && state_d == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        alu_op_d     = 3'b000;
        pc_write_d   = 1'b0;
        ir_write_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_a_d  = 1'b0;
        branch_eq_d  = 1'b0;
        branch_ne_d  = 1'b0;
        illegal_d    = 1'b0;
        alu_src_b_d  = SRCB_REG;
        pc_src_d     = PC_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_read_d  = 1'b1;
                ir_write_d  = 1'b1;
                alu_src_b_d = SRCB_FOUR;
                alu_op_d    = ALU_ADD;
                if (mem_go) begin
                    pc_write_d = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op_d    = ALU_ADD;
                alu_src_b_d = SRCB_BRANCH;
                if (op_q == OP_J) begin
                    pc_write_d = 1'b1;
                    pc_src_d   = PC_JUMP;
                    state_d    = ST_FETCH;
                    retire     = 1'b1;
                end else if (!dec_legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = dec_alu_op;
                alu_src_b_d = uses_reg_b(op_q) ? SRCB_REG : SRCB_IMM;
                if (op_q == OP_BEQ || op_q == OP_BNE) begin
                    branch_eq_d = (op_q == OP_BEQ);
                    branch_ne_d = (op_q == OP_BNE);
                    pc_src_d    = PC_TARGET;
                    state_d     = ST_FETCH;
                    retire      = 1'b1;
                end else if (is_mem_op(op_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_read_d  = (op_q == OP_LW);
                mem_write_d = (op_q == OP_SW);
                if (mem_go) begin
                    if (op_q == OP_LW) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write_d  = 1'b1;
                reg_dst_d    = (op_q == OP_RTYPE);
                mem_to_reg_d = (op_q == OP_LW);
                state_d      = ST_FETCH;
                retire       = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // run_q clears asynchronously, so every output drops the moment reset asserts.
    assign ALUOp       = run_q ? alu_op_d    : 3'b000;
    assign alu_src_b   = run_q ? alu_src_b_d : 2'b00;
    assign pc_src      = run_q ? pc_src_d    : 2'b00;
    assign pc_write    = run_q & pc_write_d;
    assign ir_write    = run_q & ir_write_d;
    assign mem_read    = run_q & mem_read_d;
    assign mem_write   = run_q & mem_write_d;
    assign reg_write   = run_q & reg_write_d;
    assign reg_dst     = run_q & reg_dst_d;
    assign mem_to_reg  = run_q & mem_to_reg_d;
    assign alu_src_a   = run_q & alu_src_a_d;
    assign branch_eq   = run_q & branch_eq_d;
    assign branch_ne   = run_q & branch_ne_d;
    assign illegal_op  = run_q & illegal_d;
    assign state       = run_q ? state_q : ST_FETCH;
    assign instr_count = count_q;

endmodule
